// File: rtl/pe_array_stu_arbiter.sv
// Packet-granular round-robin arbiter from the PE array stu links onto one registered upstream port.
// Optional mid-packet stall timeout is compiled in with `define STU_ARB_PKT_TIMEOUT_EN.
module pe_array_stu_arbiter #(
  parameter int NUM_PE         = 32,
  parameter int CNTL_W         = 2,
  parameter int TYPE_W         = 2,
  parameter int DATA_W         = 64,
  parameter int OOB_W          = 32,
  parameter int ID_W           = $clog2(NUM_PE),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic [NUM_PE-1:0]          pe__stu__valid,
  input  logic [NUM_PE*CNTL_W-1:0]   pe__stu__cntl,
  input  logic [NUM_PE*TYPE_W-1:0]   pe__stu__type,
  input  logic [NUM_PE*DATA_W-1:0]   pe__stu__data,
  input  logic [NUM_PE*OOB_W-1:0]    pe__stu__oob_data,
  output logic [NUM_PE-1:0]          stu__pe__ready,
  output logic                       arb__stu__valid,
  output logic [CNTL_W-1:0]          arb__stu__cntl,
  output logic [TYPE_W-1:0]          arb__stu__type,
  output logic [DATA_W-1:0]          arb__stu__data,
  output logic [OOB_W-1:0]           arb__stu__oob_data,
  output logic [ID_W-1:0]            arb__stu__src_id,
  input  logic                       stu__arb__ready,
  output logic                       arb__sys__proto_err,
  output logic                       arb__sys__timeout
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [ID_W:0] PE_COUNT = (ID_W+1)'(NUM_PE);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   next_ptr;
  logic [NUM_PE-1:0] som_req;
  logic [NUM_PE-1:0] bad_req;
  logic [ID_W:0]     scan;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [CNTL_W-1:0] grant_cntl;
  logic              grant_valid;
  logic              can_load;
  logic              accept;
  logic              timeout_hit;

  always_comb begin
    som_req = '0;
    bad_req = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      som_req[i] = pe__stu__valid[i] & pe__stu__cntl[i*CNTL_W+1];
      bad_req[i] = pe__stu__valid[i] & ~pe__stu__cntl[i*CNTL_W+1];
    end
  end

  // First SOM requester at or after rr_ptr, wrapping around the array.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan >= PE_COUNT) scan = scan - PE_COUNT;
      if (!pick_found && som_req[scan[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[ID_W-1:0];
      end
    end
  end

  assign grant_valid = pe__stu__valid[grant];
  assign grant_cntl  = pe__stu__cntl[grant*CNTL_W +: CNTL_W];
  assign can_load    = !arb__stu__valid || stu__arb__ready;
  assign accept      = (state == LOCKED) && grant_valid && can_load;
  assign next_ptr    = (grant == ID_W'(NUM_PE - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    stu__pe__ready = '0;
    if (state == LOCKED) stu__pe__ready[grant] = can_load;
  end

`ifdef STU_ARB_PKT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_cnt;

  assign timeout_hit = (state == LOCKED) && !grant_valid &&
                       (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive granted-PE idle cycles; a valid-but-backpressured beat holds the count.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      stall_cnt <= '0;
    end else if (state != LOCKED || accept || timeout_hit) begin
      stall_cnt <= '0;
    end else if (!grant_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant               <= '0;
      arb__stu__valid     <= 1'b0;
      arb__stu__cntl      <= '0;
      arb__stu__type      <= '0;
      arb__stu__data      <= '0;
      arb__stu__oob_data  <= '0;
      arb__stu__src_id    <= '0;
      arb__sys__proto_err <= 1'b0;
      arb__sys__timeout   <= 1'b0;
    end else begin
      arb__sys__proto_err <= (state == IDLE) && (|bad_req);
      arb__sys__timeout   <= timeout_hit;

      if (accept) begin
        arb__stu__valid    <= 1'b1;
        arb__stu__cntl     <= grant_cntl;
        arb__stu__type     <= pe__stu__type[grant*TYPE_W +: TYPE_W];
        arb__stu__data     <= pe__stu__data[grant*DATA_W +: DATA_W];
        arb__stu__oob_data <= pe__stu__oob_data[grant*OOB_W +: OOB_W];
        arb__stu__src_id   <= grant;
      end else if (stu__arb__ready) begin
        arb__stu__valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if ((accept && grant_cntl[0]) || timeout_hit) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_stu_arbiter.sv
// Directed self-checking bench for pe_array_stu_arbiter; a small per-PE packet model drives the links.
module tb_pe_array_stu_arbiter;

  localparam int NUM_PE = 32;
  localparam int CNTL_W = 2;
  localparam int TYPE_W = 2;
  localparam int DATA_W = 64;
  localparam int OOB_W  = 32;
  localparam int ID_W   = 5;

  logic                     clk = 1'b0;
  logic                     reset_poweron = 1'b0;
  logic [NUM_PE-1:0]        pe__stu__valid;
  logic [NUM_PE*CNTL_W-1:0] pe__stu__cntl;
  logic [NUM_PE*TYPE_W-1:0] pe__stu__type;
  logic [NUM_PE*DATA_W-1:0] pe__stu__data;
  logic [NUM_PE*OOB_W-1:0]  pe__stu__oob_data;
  logic [NUM_PE-1:0]        stu__pe__ready;
  logic                     arb__stu__valid;
  logic [CNTL_W-1:0]        arb__stu__cntl;
  logic [TYPE_W-1:0]        arb__stu__type;
  logic [DATA_W-1:0]        arb__stu__data;
  logic [OOB_W-1:0]         arb__stu__oob_data;
  logic [ID_W-1:0]          arb__stu__src_id;
  logic                     stu__arb__ready = 1'b1;
  logic                     arb__sys__proto_err;
  logic                     arb__sys__timeout;

  int errors = 0;
  int checks = 0;

  int pkt_len[NUM_PE];
  int beat[NUM_PE];
  bit active[NUM_PE];
  bit hold[NUM_PE];
  bit bad[NUM_PE];
  logic [NUM_PE-1:0] fire;
  int trace[$];
  int log_id[$];
  logic [DATA_W-1:0] log_data[$];

  pe_array_stu_arbiter #(
    .NUM_PE(NUM_PE), .CNTL_W(CNTL_W), .TYPE_W(TYPE_W), .DATA_W(DATA_W),
    .OOB_W(OOB_W), .ID_W(ID_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .pe__stu__valid(pe__stu__valid),
    .pe__stu__cntl(pe__stu__cntl),
    .pe__stu__type(pe__stu__type),
    .pe__stu__data(pe__stu__data),
    .pe__stu__oob_data(pe__stu__oob_data),
    .stu__pe__ready(stu__pe__ready),
    .arb__stu__valid(arb__stu__valid),
    .arb__stu__cntl(arb__stu__cntl),
    .arb__stu__type(arb__stu__type),
    .arb__stu__data(arb__stu__data),
    .arb__stu__oob_data(arb__stu__oob_data),
    .arb__stu__src_id(arb__stu__src_id),
    .stu__arb__ready(stu__arb__ready),
    .arb__sys__proto_err(arb__sys__proto_err),
    .arb__sys__timeout(arb__sys__timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] beat_data(int pe, int b);
    return {8'hD0, 40'h0, 8'(pe), 8'(b)};
  endfunction

  task automatic update_drive();
    for (int i = 0; i < NUM_PE; i++) begin
      pe__stu__valid[i] = (active[i] && !hold[i]) || bad[i];
      pe__stu__cntl[i*CNTL_W +: CNTL_W] = bad[i] ? 2'b00 :
                                          {beat[i] == 0, beat[i] == pkt_len[i] - 1};
      pe__stu__type[i*TYPE_W +: TYPE_W] = 2'(beat[i]);
      pe__stu__data[i*DATA_W +: DATA_W] = beat_data(i, beat[i]);
      pe__stu__oob_data[i*OOB_W +: OOB_W] = 32'(i);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_PE; i++) begin
      active[i] = 0; hold[i] = 0; bad[i] = 0; beat[i] = 0; pkt_len[i] = 1;
    end
    fire = '0;
    trace.delete(); log_id.delete(); log_data.delete();
  endtask

  task automatic start_pkt(int pe, int len);
    active[pe] = 1; beat[pe] = 0; pkt_len[pe] = len;
  endtask

  // Drive the current beats, let them settle, then record handshakes seen this cycle.
  task automatic sample();
    update_drive();
    #1;
    fire = pe__stu__valid & stu__pe__ready;
    trace.push_back(arb__stu__valid ? int'(arb__stu__src_id) : -1);
    if (arb__stu__valid && stu__arb__ready) begin
      log_id.push_back(int'(arb__stu__src_id));
      log_data.push_back(arb__stu__data);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_PE; i++) begin
      if (fire[i] && active[i]) begin
        if (beat[i] == pkt_len[i] - 1) active[i] = 0;
        else beat[i]++;
      end
    end
  endtask

  task automatic test_reset();
    clear_all();
    reset_poweron = 1'b0;
    update_drive();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (arb__stu__valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", arb__stu__valid);
    end
    reset_poweron = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (stu__pe__ready !== '0) begin
      errors++; $display("[TB] FAIL reset_ready: got %h expected 0", stu__pe__ready);
    end
    checks++;
    if (arb__stu__src_id !== '0 || arb__stu__data !== '0) begin
      errors++; $display("[TB] FAIL reset_fields: got id=%0d data=%h expected 0/0", arb__stu__src_id, arb__stu__data);
    end
    checks++;
    if (arb__sys__proto_err !== 1'b0 || arb__sys__timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pulses: got perr=%0b to=%0b expected 0/0", arb__sys__proto_err, arb__sys__timeout);
    end
  endtask

  task automatic test_round_robin();
    int exp_trace[11];
    int exp_id[6];
    int exp_beat[6];
    exp_trace = '{-1, -1, 0, 0, -1, 3, 3, -1, 7, 7, -1};
    exp_id    = '{0, 0, 3, 3, 7, 7};
    exp_beat  = '{0, 1, 0, 1, 0, 1};
    clear_all();
    stu__arb__ready = 1'b1;
    start_pkt(3, 2); start_pkt(7, 2); start_pkt(0, 2);
    for (int k = 0; k < 11; k++) begin
      sample();
      advance();
    end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (trace[k] !== exp_trace[k]) begin
        errors++; $display("[TB] FAIL rr_trace[%0d]: got %0d expected %0d", k, trace[k], exp_trace[k]);
      end
    end
    checks++;
    if (log_id.size() != 6) begin
      errors++; $display("[TB] FAIL rr_count: got %0d beats expected 6", log_id.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (log_id[k] !== exp_id[k] || log_data[k] !== beat_data(exp_id[k], exp_beat[k])) begin
          errors++; $display("[TB] FAIL rr_beat[%0d]: got id=%0d data=%h expected id=%0d data=%h",
                             k, log_id[k], log_data[k], exp_id[k], beat_data(exp_id[k], exp_beat[k]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    start_pkt(5, 4);
    for (int k = 0; k < 10; k++) begin
      stu__arb__ready = !(k >= 2 && k <= 4);
      sample();
      if (k == 1) begin
        checks++;
        if (stu__pe__ready[5] !== 1'b1) begin
          errors++; $display("[TB] FAIL bp_ready_open: got %0b expected 1", stu__pe__ready[5]);
        end
      end
      if (k >= 2 && k <= 4) begin
        checks++;
        if (stu__pe__ready[5] !== 1'b0) begin
          errors++; $display("[TB] FAIL bp_ready_stall[%0d]: got %0b expected 0", k, stu__pe__ready[5]);
        end
        checks++;
        if (arb__stu__valid !== 1'b1 || arb__stu__data !== beat_data(5, 0) || arb__stu__cntl !== 2'b10) begin
          errors++; $display("[TB] FAIL bp_hold[%0d]: got v=%0b data=%h cntl=%b expected 1/%h/10",
                             k, arb__stu__valid, arb__stu__data, arb__stu__cntl, beat_data(5, 0));
        end
      end
      advance();
    end
    stu__arb__ready = 1'b1;
    checks++;
    if (log_id.size() != 4) begin
      errors++; $display("[TB] FAIL bp_count: got %0d beats expected 4", log_id.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (log_id[b] !== 5 || log_data[b] !== beat_data(5, b)) begin
          errors++; $display("[TB] FAIL bp_order[%0d]: got id=%0d data=%h expected id=5 data=%h",
                             b, log_id[b], log_data[b], beat_data(5, b));
        end
      end
    end
  endtask

  task automatic test_mid_packet();
    int exp_id[6];
    exp_id = '{2, 2, 2, 2, 9, 9};
    clear_all();
    start_pkt(2, 4);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) start_pkt(9, 2);
      sample();
      if (k >= 2 && k <= 5) begin
        checks++;
        if (stu__pe__ready[9] !== 1'b0) begin
          errors++; $display("[TB] FAIL mid_wait[%0d]: got ready9=%0b expected 0", k, stu__pe__ready[9]);
        end
      end
      if (k == 6) begin
        checks++;
        if (stu__pe__ready !== 32'h0000_0200) begin
          errors++; $display("[TB] FAIL mid_grant: got ready=%h expected 00000200", stu__pe__ready);
        end
      end
      advance();
    end
    checks++;
    if (log_id.size() != 6) begin
      errors++; $display("[TB] FAIL mid_count: got %0d beats expected 6", log_id.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (log_id[k] !== exp_id[k]) begin
          errors++; $display("[TB] FAIL mid_order[%0d]: got id=%0d expected %0d", k, log_id[k], exp_id[k]);
        end
      end
    end
  endtask

  task automatic test_proto_err();
    clear_all();
    bad[4] = 1;
    sample();
    checks++;
    if (stu__pe__ready !== '0) begin
      errors++; $display("[TB] FAIL perr_ready0: got %h expected 0", stu__pe__ready);
    end
    advance();
    sample();
    checks++;
    if (arb__sys__proto_err !== 1'b1 || stu__pe__ready !== '0) begin
      errors++; $display("[TB] FAIL perr_pulse1: got perr=%0b ready=%h expected 1/0", arb__sys__proto_err, stu__pe__ready);
    end
    advance();
    bad[4] = 0;
    sample();
    checks++;
    if (arb__sys__proto_err !== 1'b1 || arb__stu__valid !== 1'b0) begin
      errors++; $display("[TB] FAIL perr_pulse2: got perr=%0b valid=%0b expected 1/0", arb__sys__proto_err, arb__stu__valid);
    end
    advance();
    sample();
    checks++;
    if (arb__sys__proto_err !== 1'b0 || arb__stu__valid !== 1'b0) begin
      errors++; $display("[TB] FAIL perr_clear: got perr=%0b valid=%0b expected 0/0", arb__sys__proto_err, arb__stu__valid);
    end
    advance();
  endtask

  task automatic test_reset_mid_packet();
    clear_all();
    start_pkt(6, 3);
    sample(); advance();
    sample(); advance();
    sample();
    checks++;
    if (arb__stu__valid !== 1'b1 || arb__stu__src_id !== 5'd6) begin
      errors++; $display("[TB] FAIL rstmid_pre: got v=%0b id=%0d expected 1/6", arb__stu__valid, arb__stu__src_id);
    end
    #1 reset_poweron = 1'b0;
    #1;
    checks++;
    if (arb__stu__valid !== 1'b0 || stu__pe__ready !== '0 || arb__stu__data !== '0 ||
        arb__stu__src_id !== '0 || arb__stu__cntl !== '0) begin
      errors++; $display("[TB] FAIL rstmid_clear: got v=%0b ready=%h data=%h id=%0d cntl=%b expected all 0",
                         arb__stu__valid, stu__pe__ready, arb__stu__data, arb__stu__src_id, arb__stu__cntl);
    end
    clear_all();
    update_drive();
    #2 reset_poweron = 1'b1;
    @(posedge clk);
    #1;
    start_pkt(0, 1);
    start_pkt(12, 1);
    sample(); advance();
    sample();
    checks++;
    if (stu__pe__ready !== 32'h0000_0001) begin
      errors++; $display("[TB] FAIL rstmid_rr: got ready=%h expected 00000001", stu__pe__ready);
    end
    advance();
    sample();
    checks++;
    if (arb__stu__valid !== 1'b1 || arb__stu__src_id !== 5'd0 || arb__stu__cntl !== 2'b11) begin
      errors++; $display("[TB] FAIL rstmid_out: got v=%0b id=%0d cntl=%b expected 1/0/11",
                         arb__stu__valid, arb__stu__src_id, arb__stu__cntl);
    end
    advance();
    repeat (4) begin sample(); advance(); end
  endtask

`ifdef STU_ARB_PKT_TIMEOUT_EN
  task automatic test_timeout();
    clear_all();
    start_pkt(1, 2);
    for (int k = 0; k < 22; k++) begin
      if (k == 2) hold[1] = 1;
      if (k == 10) start_pkt(2, 1);
      sample();
      if (k == 17) begin
        checks++;
        if (arb__sys__timeout !== 1'b0) begin
          errors++; $display("[TB] FAIL to_early: got %0b expected 0", arb__sys__timeout);
        end
      end
      if (k == 18) begin
        checks++;
        if (arb__sys__timeout !== 1'b1 || stu__pe__ready !== '0) begin
          errors++; $display("[TB] FAIL to_pulse: got to=%0b ready=%h expected 1/0", arb__sys__timeout, stu__pe__ready);
        end
      end
      if (k == 19) begin
        checks++;
        if (arb__sys__timeout !== 1'b0 || stu__pe__ready !== 32'h0000_0004) begin
          errors++; $display("[TB] FAIL to_regrant: got to=%0b ready=%h expected 0/00000004", arb__sys__timeout, stu__pe__ready);
        end
      end
      advance();
    end
    clear_all();
  endtask
`endif

  initial begin
    clear_all();
    update_drive();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_mid_packet();
    test_proto_err();
    test_reset_mid_packet();
`ifdef STU_ARB_PKT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] run did not complete");
  end

endmodule
